// File: rtl/req_enc_pkg.sv
// Shared constants, types and helpers for the queued 16-to-4 request encoder.
// Contents:
//   NREQ, CODE_W, CNT_W  widths (NREQ must equal 2**CODE_W)
//   code_t               encoded index type
//   req_vec_t            one bit per request line
//   state_t              issue FSM states {IDLE, PRESENT}
//   popcount()           number of set bits in a request vector
//   onehot()             request vector with only bit c set
package req_enc_pkg;

  localparam int unsigned NREQ   = 16;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 5;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [NREQ-1:0]   req_vec_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Count of pending lines, 0..NREQ
  function automatic logic [CNT_W-1:0] popcount(input req_vec_t v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Clear mask for an accepted code
  function automatic req_vec_t onehot(input code_t c);
    req_vec_t v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first over the pending set with a rotating start point.
// The search visits start, start+1, ... wrapping modulo NREQ; the first set
// bit wins. With start tied to 0 this is plain lowest-index-first priority.
// Ports:
//   i_pending  [NREQ]    pending request set
//   i_start    [CODE_W]  first index to examine
//   o_found_c  1         at least one bit of i_pending is set
//   o_idx_c    [CODE_W]  winning index (0 when nothing is found)
module prio_pick
  import req_enc_pkg::*;
(
  input  logic [NREQ-1:0]   i_pending,
  input  logic [CODE_W-1:0] i_start,
  output logic              o_found_c,
  output logic [CODE_W-1:0] o_idx_c
);

  // CODE_W-bit addition wraps naturally because NREQ == 2**CODE_W
  always_comb begin
    code_t j;
    o_found_c = 1'b0;
    o_idx_c   = '0;
    j         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = i_start + CODE_W'(k);
      if (!o_found_c && i_pending[j]) begin
        o_found_c = 1'b1;
        o_idx_c   = j;
      end
    end
  end

endmodule

// File: rtl/req_encoder_16to4.sv
// Queued 16-to-4 encoder: captures active-low request pulses into a sticky
// pending set and hands out one pending index at a time over valid/ready.
// Build option: define PRIO_ROTATE_EN for round-robin picking (search starts
// after the last accepted code); otherwise the lowest pending index wins.
// Ports:
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   enable_n     in   1         0 = capture requests and issue codes
//   req_n        in   [0:15]    active-low request lines, sampled every clk
//   code         out  [3:0]     encoded index, meaningful while valid=1
//   valid        out  1         code is presented
//   ready        in   1         consumer accepts when valid & ready at an edge
//   pending_cnt  out  [4:0]     popcount of the pending set, one clk behind
module req_encoder_16to4
  import req_enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_n,
  input  logic [0:NREQ-1]   req_n,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [CNT_W-1:0]  pending_cnt
);

  state_t           r_state;
  req_vec_t         r_pending;
  code_t            r_code;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
`ifdef PRIO_ROTATE_EN
  code_t            r_last_ptr;
`endif

  req_vec_t w_req;
  req_vec_t w_clr;
  req_vec_t w_pending_nxt;
  logic     w_accept;
  code_t    w_start;
  logic     w_found;
  code_t    w_idx;

  // req_n is declared [0:15]; map line i to pending bit i explicitly
  always_comb begin
    w_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_req[i] = ~req_n[i] & ~enable_n;
    end
  end

  assign w_accept = r_valid & ready;
  assign w_clr    = w_accept ? onehot(r_code) : '0;

  // Clear first, then OR in new requests so a line held through its own
  // accept stays pending
  assign w_pending_nxt = (r_pending & ~w_clr) | w_req;

`ifdef PRIO_ROTATE_EN
  assign w_start = r_last_ptr + code_t'(1);
`else
  assign w_start = '0;
`endif

  prio_pick u_pick (
    .i_pending (r_pending),
    .i_start   (w_start),
    .o_found_c (w_found),
    .o_idx_c   (w_idx)
  );

  // Pending set, count and issue FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= '0;
`ifdef PRIO_ROTATE_EN
      r_last_ptr <= code_t'(NREQ - 1);
`endif
    end else begin
      r_pending <= w_pending_nxt;
      r_cnt     <= popcount(r_pending);
      case (r_state)
        IDLE: begin
          if (!enable_n && w_found) begin
            r_code  <= w_idx;
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          // code and valid hold until the consumer takes them
          if (w_accept) begin
            r_valid    <= 1'b0;
            r_state    <= IDLE;
`ifdef PRIO_ROTATE_EN
            r_last_ptr <= r_code;
`endif
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign code        = r_code;
  assign valid       = r_valid;
  assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_req_encoder_16to4.sv
// Directed bench for req_encoder_16to4: a per-cycle vector table for the
// single-pulse and simultaneous-request cases, then hand-written sequences
// for backpressure, enable gating, set-wins and async reset.
module tb_req_encoder_16to4;

  logic        clk;
  logic        rst_n;
  logic        enable_n;
  logic [0:15] req_n;
  logic [3:0]  code;
  logic        valid;
  logic        ready;
  logic [4:0]  pending_cnt;

  int n_tests;
  int n_fail;

  req_encoder_16to4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_n    (enable_n),
    .req_n       (req_n),
    .code        (code),
    .valid       (valid),
    .ready       (ready),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en_n;
    logic [15:0] req_mask;   // bit i set = line i driven low
    logic        rdy;
    logic        exp_valid;
    logic        chk_code;
    logic [3:0]  exp_code;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) req_n[i] = ~mask[i];
  endtask

  // Advance one edge and settle for sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en_n, input logic [15:0] m, input logic r,
                              input logic v, input logic cc, input logic [3:0] c,
                              input logic [4:0] n);
    vec_t t;
    t.en_n = en_n; t.req_mask = m; t.rdy = r;
    t.exp_valid = v; t.chk_code = cc; t.exp_code = c; t.exp_cnt = n;
    return t;
  endfunction

  initial begin
    logic [3:0]  first_c, second_c;
    logic [15:0] seen;
    int          ncodes;
    int          peak;

    n_tests = 0;
    n_fail  = 0;

`ifdef PRIO_ROTATE_EN
    first_c  = 4'd9;   // last accepted was 5, search starts at 6
    second_c = 4'd3;
`else
    first_c  = 4'd3;
    second_c = 4'd9;
`endif
    // Each row: inputs applied before an edge, outputs expected after it
    vecs[0] = mk(1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);   // req 5 pulse
    vecs[1] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd5, 5'd1);   // code 5 presented
    vecs[2] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1);   // accepted
    vecs[3] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);
    vecs[4] = mk(1'b0, 16'h0208, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);   // req 3 and 9
    vecs[5] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, first_c, 5'd2);
    vecs[6] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd2);
    vecs[7] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, second_c, 5'd1);
    vecs[8] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd1);
    vecs[9] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0);

    // Reset state
    rst_n = 1'b0; enable_n = 1'b0; ready = 1'b0; set_req(16'h0000);
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single pulse and simultaneous requests
    for (int i = 0; i < 10; i++) begin
      enable_n = vecs[i].en_n;
      ready    = vecs[i].rdy;
      set_req(vecs[i].req_mask);
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_code)
        chk($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
      chk($sformatf("vec%0d_cnt", i), 32'(pending_cnt), 32'(vecs[i].exp_cnt));
    end

    // Backpressure: code 9 held while request 1 arrives
    ready = 1'b0;
    set_req(16'h0200);
    cyc();
    set_req(16'h0000);
    cyc();
    chk("bp_first_valid", 32'(valid), 32'd1);
    chk("bp_first_code", 32'(code), 32'd9);
    peak = 0;
    for (int k = 0; k < 10; k++) begin
      set_req(k == 0 ? 16'h0002 : 16'h0000);
      cyc();
      chk($sformatf("bp_hold%0d_code", k), 32'(code), 32'd9);
      chk($sformatf("bp_hold%0d_valid", k), 32'(valid), 32'd1);
      if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
    end
    ready = 1'b1;
    cyc();
    chk("bp_accept_valid", 32'(valid), 32'd0);
    cyc();
    chk("bp_next_valid", 32'(valid), 32'd1);
    chk("bp_next_code", 32'(code), 32'd1);
    cyc();
    chk("bp_peak", 32'(peak), 32'd2);
    cyc();
    chk("bp_drained_cnt", 32'(pending_cnt), 32'd0);

    // Enable gating, then all 16 lines at once
    enable_n = 1'b1;
    set_req(16'hFFFF);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("en_off%0d_valid", k), 32'(valid), 32'd0);
      chk($sformatf("en_off%0d_cnt", k), 32'(pending_cnt), 32'd0);
    end
    enable_n = 1'b0;
    cyc();
    set_req(16'h0000);
    seen = '0; ncodes = 0; peak = 0;
    for (int k = 0; k < 80; k++) begin
      cyc();
      if (int'(pending_cnt) > peak) peak = int'(pending_cnt);
      if (valid) begin
        ncodes++;
        seen[code] = 1'b1;
      end
    end
    chk("en_ncodes", 32'(ncodes), 32'd16);
    chk("en_seen", 32'(seen), 32'h0000FFFF);
    chk("en_peak", 32'(peak), 32'd16);
    chk("en_final_cnt", 32'(pending_cnt), 32'd0);

    // Set wins: line 7 held low through its own accept
    set_req(16'h0080);
    cyc();
    cyc();
    chk("sw_first_valid", 32'(valid), 32'd1);
    chk("sw_first_code", 32'(code), 32'd7);
    cyc();
    chk("sw_accept_valid", 32'(valid), 32'd0);
    cyc();
    chk("sw_reissue_valid", 32'(valid), 32'd1);
    chk("sw_reissue_code", 32'(code), 32'd7);
    set_req(16'h0000);
    cyc();
    cyc();
    cyc();
    chk("sw_drain_valid", 32'(valid), 32'd0);
    chk("sw_drain_cnt", 32'(pending_cnt), 32'd0);

    // Async reset while a code is presented
    ready = 1'b0;
    set_req(16'h0004);
    cyc();
    set_req(16'h0000);
    cyc();
    chk("ar_pre_valid", 32'(valid), 32'd1);
    chk("ar_pre_code", 32'(code), 32'd2);
    chk("ar_pre_cnt", 32'(pending_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(valid), 32'd0);
    chk("ar_code", 32'(code), 32'd0);
    chk("ar_cnt", 32'(pending_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("ar_after_valid", 32'(valid), 32'd0);
    chk("ar_after_cnt", 32'(pending_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
